// File: rtl/ase_emul_host_chan_req_mux.sv
// N-port request/response multiplexer for ASE host-channel emulation: round-robin request merge
// with port-indexed tags, indexed response return, per-port outstanding-read throttling.
module ase_emul_host_chan_req_mux #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned TAG_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned IDX_WIDTH       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            afu_req_valid,
  output logic [NUM_PORTS-1:0]            afu_req_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] afu_req_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]  afu_req_tag,
  input  logic [NUM_PORTS-1:0]            afu_req_needs_rsp,
  output logic                            fiu_req_valid,
  input  logic                            fiu_req_ready,
  output logic [DATA_WIDTH-1:0]           fiu_req_data,
  output logic [IDX_WIDTH+TAG_WIDTH-1:0]  fiu_req_tag,
  input  logic                            fiu_rsp_valid,
  input  logic                            fiu_rsp_last,
  input  logic [DATA_WIDTH-1:0]           fiu_rsp_data,
  input  logic [IDX_WIDTH+TAG_WIDTH-1:0]  fiu_rsp_tag,
  output logic [NUM_PORTS-1:0]            afu_rsp_valid,
  output logic                            afu_rsp_last,
  output logic [DATA_WIDTH-1:0]           afu_rsp_data,
  output logic [TAG_WIDTH-1:0]            afu_rsp_tag,
  output logic [NUM_PORTS-1:0]            port_full,
  output logic                            err_unexpected_rsp
);

  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_OUTSTANDING);

  logic [CntWidth-1:0]            cnt_q [NUM_PORTS];
  logic [CntWidth-1:0]            cnt_d [NUM_PORTS];
  logic [IDX_WIDTH-1:0]           ptr_q, ptr_d;
  logic                           req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0]          req_data_q, req_data_d;
  logic [IDX_WIDTH+TAG_WIDTH-1:0] req_tag_q, req_tag_d;
  logic [NUM_PORTS-1:0]           rsp_valid_q, rsp_valid_d;
  logic                           rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0]          rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]           rsp_tag_q, rsp_tag_d;
  logic                           err_q, err_d;

  logic [NUM_PORTS-1:0]  eligible, upper_mask, pick, grant, inc, dec, rsp_hit;
  logic [IDX_WIDTH-1:0]  grant_idx, rsp_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic                  can_load, accept, rsp_idx_ok, underflow;

  // Arbitration: prefer eligible ports at or above the pointer, else wrap to the lowest.
  always_comb begin
    port_full  = '0;
    eligible   = '0;
    upper_mask = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_full[i]  = (cnt_q[i] == CntMax);
      eligible[i]   = afu_req_valid[i] && !(afu_req_needs_rsp[i] && port_full[i]);
      upper_mask[i] = (i >= 32'(ptr_q));
    end
    pick      = (|(eligible & upper_mask)) ? (eligible & upper_mask) : eligible;
    grant     = pick & ~(pick - 1'b1);
    grant_idx = '0;
    sel_data  = '0;
    sel_tag   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_WIDTH'(i);
        sel_data  = afu_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag   = afu_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    can_load      = !req_valid_q || fiu_req_ready;
    accept        = (|grant) && can_load && !reset;
    afu_req_ready = accept ? grant : '0;
  end

  always_comb begin
    ptr_d       = ptr_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    req_tag_d   = req_tag_q;
    if (accept) begin
      req_valid_d = 1'b1;
      req_data_d  = sel_data;
      req_tag_d   = {grant_idx, sel_tag};
      ptr_d       = (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end else if (fiu_req_ready) begin
      req_valid_d = 1'b0;
    end
  end

  // Response routing and outstanding-count bookkeeping.
  always_comb begin
    rsp_idx    = fiu_rsp_tag[TAG_WIDTH +: IDX_WIDTH];
    rsp_idx_ok = (32'(rsp_idx) < NUM_PORTS);
    rsp_hit    = '0;
    inc        = '0;
    dec        = '0;
    underflow  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rsp_hit[i] = fiu_rsp_valid && rsp_idx_ok && (32'(rsp_idx) == i);
      inc[i]     = afu_req_valid[i] && afu_req_ready[i] && afu_req_needs_rsp[i];
      dec[i]     = rsp_hit[i] && fiu_rsp_last;
      cnt_d[i]   = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) underflow = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    rsp_valid_d = rsp_hit;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (fiu_rsp_valid) begin
      rsp_last_d = fiu_rsp_last;
      rsp_data_d = fiu_rsp_data;
      rsp_tag_d  = fiu_rsp_tag[TAG_WIDTH-1:0];
    end
    err_d = err_q || (fiu_rsp_valid && !rsp_idx_ok) || underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign fiu_req_valid      = req_valid_q;
  assign fiu_req_data       = req_data_q;
  assign fiu_req_tag        = req_tag_q;
  assign afu_rsp_valid      = rsp_valid_q;
  assign afu_rsp_last       = rsp_last_q;
  assign afu_rsp_data       = rsp_data_q;
  assign afu_rsp_tag        = rsp_tag_q;
  assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_ase_emul_host_chan_req_mux.sv
// Directed bench for ase_emul_host_chan_req_mux: 4-port instance with a small outstanding limit,
// plus a 3-port instance for out-of-range response indices.
module tb_ase_emul_host_chan_req_mux;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW+TW-1:0] tag;
    logic [DW-1:0]    data;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]       a_req_valid, a_req_ready, a_needs;
  logic [4*DW-1:0]  a_req_data;
  logic [4*TW-1:0]  a_req_tag;
  logic             fiu_req_valid, fiu_req_ready;
  logic [DW-1:0]    fiu_req_data;
  logic [IW+TW-1:0] fiu_req_tag;
  logic             rsp_valid, rsp_last;
  logic [DW-1:0]    rsp_data;
  logic [IW+TW-1:0] rsp_tag;
  logic [3:0]       a_rsp_valid, a_full;
  logic             a_rsp_last, a_err;
  logic [DW-1:0]    a_rsp_data;
  logic [TW-1:0]    a_rsp_tag;

  logic             b_in_valid;
  logic [IW+TW-1:0] b_in_tag;
  logic [2:0]       b_req_ready, b_rsp_valid, b_full;
  logic             b_fiu_req_valid, b_rsp_last, b_err;
  logic [DW-1:0]    b_fiu_req_data, b_rsp_data;
  logic [IW+TW-1:0] b_fiu_req_tag;
  logic [TW-1:0]    b_rsp_tag;

  ase_emul_host_chan_req_mux #(
    .NUM_PORTS(4), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .afu_req_valid(a_req_valid), .afu_req_ready(a_req_ready), .afu_req_data(a_req_data),
    .afu_req_tag(a_req_tag), .afu_req_needs_rsp(a_needs),
    .fiu_req_valid(fiu_req_valid), .fiu_req_ready(fiu_req_ready),
    .fiu_req_data(fiu_req_data), .fiu_req_tag(fiu_req_tag),
    .fiu_rsp_valid(rsp_valid), .fiu_rsp_last(rsp_last), .fiu_rsp_data(rsp_data),
    .fiu_rsp_tag(rsp_tag),
    .afu_rsp_valid(a_rsp_valid), .afu_rsp_last(a_rsp_last), .afu_rsp_data(a_rsp_data),
    .afu_rsp_tag(a_rsp_tag), .port_full(a_full), .err_unexpected_rsp(a_err)
  );

  ase_emul_host_chan_req_mux #(
    .NUM_PORTS(3), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(2)
  ) dut3 (
    .clk(clk), .reset(reset),
    .afu_req_valid(3'b000), .afu_req_ready(b_req_ready), .afu_req_data({(3*DW){1'b0}}),
    .afu_req_tag({(3*TW){1'b0}}), .afu_req_needs_rsp(3'b000),
    .fiu_req_valid(b_fiu_req_valid), .fiu_req_ready(1'b1),
    .fiu_req_data(b_fiu_req_data), .fiu_req_tag(b_fiu_req_tag),
    .fiu_rsp_valid(b_in_valid), .fiu_rsp_last(rsp_last), .fiu_rsp_data(rsp_data),
    .fiu_rsp_tag(b_in_tag),
    .afu_rsp_valid(b_rsp_valid), .afu_rsp_last(b_rsp_last), .afu_rsp_data(b_rsp_data),
    .afu_rsp_tag(b_rsp_tag), .port_full(b_full), .err_unexpected_rsp(b_err)
  );

  int   errors = 0;
  int   checks = 0;
  req_t exp_q[$];

  function automatic logic [TW-1:0] tag_for(int p);
    return 16'h0A00 + TW'(p);
  endfunction

  function automatic logic [DW-1:0] data_for(int p);
    return 32'hD0D0_0000 + DW'(p * 17);
  endfunction

  function automatic req_t mk(int p);
    req_t r;
    r.tag  = {IW'(p), tag_for(p)};
    r.data = data_for(p);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake on the merged channel must match the oldest expected request.
  always @(negedge clk) begin
    req_t e;
    if (!reset && fiu_req_valid && fiu_req_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_tag", 64'(fiu_req_tag), 64'(e.tag));
        check("sb_data", 64'(fiu_req_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a_req_valid = '0; a_needs = '0; fiu_req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_data = '0; rsp_tag = '0;
    b_in_valid = 1'b0; b_in_tag = '0;
    for (int p = 0; p < 4; p++) begin
      a_req_data[p*DW +: DW] = data_for(p);
      a_req_tag[p*TW +: TW]  = tag_for(p);
    end
    tick(); tick();
    check("rst_fiu_valid", 64'(fiu_req_valid), 64'd0);
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("rst_full", 64'(a_full), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_b_err", 64'(b_err), 64'd0);
    reset = 1'b0;

    // Round robin with everyone requesting and no backpressure.
    a_req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", 64'(a_req_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back(mk(k % 4));
      tick();
      check("rr_fiu_valid", 64'(fiu_req_valid), 64'd1);
      check("rr_fiu_tag", 64'(fiu_req_tag), 64'({IW'(k % 4), tag_for(k % 4)}));
    end
    a_req_valid = '0;
    tick();
    check("rr_drain", 64'(fiu_req_valid), 64'd0);

    // Backpressure: held output, no ready while stalled.
    a_req_valid = 4'b0110;
    #1;
    check("bp_first_ready", 64'(a_req_ready), 64'b0010);
    exp_q.push_back(mk(1));
    tick();
    a_req_valid = 4'b0100; fiu_req_ready = 1'b0;
    #1;
    check("bp_stall_ready", 64'(a_req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 64'(fiu_req_valid), 64'd1);
      check("bp_hold_tag", 64'(fiu_req_tag), 64'({IW'(1), tag_for(1)}));
      check("bp_hold_data", 64'(fiu_req_data), 64'(data_for(1)));
      check("bp_hold_ready", 64'(a_req_ready), 64'd0);
    end
    fiu_req_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(a_req_ready), 64'b0100);
    exp_q.push_back(mk(2));
    tick();
    a_req_valid = '0;
    check("bp_second_tag", 64'(fiu_req_tag), 64'({IW'(2), tag_for(2)}));
    tick();
    check("bp_drain", 64'(fiu_req_valid), 64'd0);

    // Throttle at two outstanding reads on port 0.
    a_needs = 4'b0001; a_req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("thr_ready", 64'(a_req_ready), 64'b0001);
      exp_q.push_back(mk(0));
      tick();
    end
    check("thr_full", 64'(a_full), 64'b0001);
    check("thr_blocked", 64'(a_req_ready), 64'd0);
    tick();
    check("thr_still_blocked", 64'(a_req_ready), 64'd0);
    rsp_valid = 1'b1; rsp_last = 1'b1; rsp_tag = {2'd0, 16'h0A00}; rsp_data = 32'h5555_0000;
    tick();
    rsp_valid = 1'b0; rsp_last = 1'b0;
    check("thr_rsp_route", 64'(a_rsp_valid), 64'b0001);
    check("thr_unfull", 64'(a_full), 64'd0);
    #1;
    check("thr_third_ready", 64'(a_req_ready), 64'b0001);
    exp_q.push_back(mk(0));
    tick();
    check("thr_full_again", 64'(a_full), 64'b0001);
    check("rsp_valid_pulse", 64'(a_rsp_valid), 64'd0);
    a_needs = '0;
    #1;
    check("thr_posted_ready", 64'(a_req_ready), 64'b0001);
    exp_q.push_back(mk(0));
    tick();
    a_req_valid = '0;
    check("thr_posted_full", 64'(a_full), 64'b0001);
    tick();

    // Routing by index, and multi-beat responses.
    rsp_valid = 1'b1; rsp_last = 1'b0; rsp_tag = {2'd3, 16'hBEEF}; rsp_data = 32'hCAFE_0001;
    tick();
    check("route_valid", 64'(a_rsp_valid), 64'b1000);
    check("route_tag", 64'(a_rsp_tag), 64'hBEEF);
    check("route_data", 64'(a_rsp_data), 64'hCAFE_0001);
    check("route_last", 64'(a_rsp_last), 64'd0);
    check("route_err", 64'(a_err), 64'd0);
    rsp_tag = {2'd0, 16'h1234}; rsp_data = 32'd2;
    tick();
    check("mb_valid", 64'(a_rsp_valid), 64'b0001);
    check("mb_full1", 64'(a_full), 64'b0001);
    rsp_data = 32'd3;
    tick();
    check("mb_full2", 64'(a_full), 64'b0001);
    rsp_last = 1'b1; rsp_data = 32'd4;
    tick();
    check("mb_last_flag", 64'(a_rsp_last), 64'd1);
    check("mb_full_clear", 64'(a_full), 64'd0);
    tick();
    rsp_valid = 1'b0; rsp_last = 1'b0;
    check("mb_no_err", 64'(a_err), 64'd0);
    tick();
    check("mb_no_err2", 64'(a_err), 64'd0);

    // Response for a port with nothing outstanding.
    rsp_valid = 1'b1; rsp_last = 1'b1; rsp_tag = {2'd2, 16'h0777};
    tick();
    rsp_valid = 1'b0; rsp_last = 1'b0;
    check("unx_err", 64'(a_err), 64'd1);
    a_needs = 4'b0100; a_req_valid = 4'b0100;
    #1;
    check("unx_ready1", 64'(a_req_ready), 64'b0100);
    exp_q.push_back(mk(2));
    tick();
    check("unx_cnt1", 64'(a_full), 64'd0);
    #1;
    check("unx_ready2", 64'(a_req_ready), 64'b0100);
    exp_q.push_back(mk(2));
    tick();
    check("unx_cnt2", 64'(a_full), 64'b0100);
    check("unx_sticky", 64'(a_err), 64'd1);

    // Three-port instance: in-range route, then out-of-range index dropped.
    b_in_valid = 1'b1; b_in_tag = {2'd2, 16'h0042};
    tick();
    check("b_route", 64'(b_rsp_valid), 64'b100);
    check("b_err_clean", 64'(b_err), 64'd0);
    b_in_tag = {2'd3, 16'h0043}; rsp_last = 1'b1;
    tick();
    b_in_valid = 1'b0; rsp_last = 1'b0;
    check("b_drop", 64'(b_rsp_valid), 64'd0);
    check("b_err", 64'(b_err), 64'd1);

    // Reset while a request is held and counters are non-zero.
    a_needs = '0; a_req_valid = 4'b1000;
    #1;
    check("rst_pre_ready", 64'(a_req_ready), 64'b1000);
    tick();
    fiu_req_ready = 1'b0; a_req_valid = '0;
    check("rst_pre_valid", 64'(fiu_req_valid), 64'd1);
    reset = 1'b1; a_req_valid = 4'hF; fiu_req_ready = 1'b1;
    rsp_valid = 1'b1; rsp_last = 1'b1; rsp_tag = {2'd1, 16'h0001};
    #1;
    check("rst_ready_gated", 64'(a_req_ready), 64'd0);
    tick();
    reset = 1'b0; rsp_valid = 1'b0; rsp_last = 1'b0;
    check("rst_fiu_valid2", 64'(fiu_req_valid), 64'd0);
    check("rst_fiu_tag2", 64'(fiu_req_tag), 64'd0);
    check("rst_rsp_valid2", 64'(a_rsp_valid), 64'd0);
    check("rst_full2", 64'(a_full), 64'd0);
    check("rst_err2", 64'(a_err), 64'd0);
    check("rst_b_err2", 64'(b_err), 64'd0);
    #1;
    check("post_rst_ready", 64'(a_req_ready), 64'b0001);
    exp_q.push_back(mk(0));
    tick();
    a_req_valid = '0;
    check("post_rst_tag", 64'(fiu_req_tag), 64'({IW'(0), tag_for(0)}));
    tick();
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
